// File: rtl/uart_receiver.sv
// 8-N-1 UART receiver, 16x oversampled, with ready/ack handshake and error flags.
// Define UART_RX_PARITY_EN to receive 8-E-1 frames with even-parity checking.
module uart_receiver #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned Div  = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic              rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]        tcnt_q, tcnt_d;
  logic [2:0]        bidx_q, bidx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_ready_q, rx_ready_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              parity_err_q, parity_err_d;
  logic              tick, fall, stop_eval, parity_ok, good;
`ifdef UART_RX_PARITY_EN
  logic              par_bit_q, par_bit_d;
`endif

  assign tick = (div_cnt_q == DivW'(Div - 1));
  assign fall = rxd_prev_q & ~rxd_s_q;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bidx_d    = bidx_q;
    shift_d   = shift_q;
    stop_eval = 1'b0;
    div_cnt_d = (state_q == StIdle || tick) ? '0 : div_cnt_q + DivW'(1);
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          tcnt_d  = 4'd0;
        end
      end
      StStart: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd7) begin
            state_d = rxd_s_q ? StIdle : StData;
            tcnt_d  = 4'd0;
            bidx_d  = 3'd0;
          end
        end
      end
      StData: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            shift_d = {rxd_s_q, shift_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            par_bit_d = rxd_s_q;
            state_d   = StStop;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (tcnt_q == 4'd15) begin
            stop_eval = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign parity_ok = ~(^{shift_q, par_bit_q});
`else
  assign parity_ok = 1'b1;
`endif

  assign good = stop_eval & rxd_s_q & parity_ok;

  always_comb begin
    rx_data_d    = good ? shift_q : rx_data_q;
    rx_valid_d   = good;
    frame_err_d  = stop_eval & ~rxd_s_q;
    parity_err_d = stop_eval & ~parity_ok;
    rx_ready_d   = good ? 1'b1 : (rd_ack ? 1'b0 : rx_ready_q);
    overrun_d    = rd_ack ? 1'b0 : (overrun_q | (good & rx_ready_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      tcnt_q       <= 4'd0;
      bidx_q       <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
`endif
    end else begin
      rxd_meta_q   <= RxD;
      rxd_s_q      <= rxd_meta_q;
      rxd_prev_q   <= rxd_s_q;
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      tcnt_q       <= tcnt_d;
      bidx_q       <= bidx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_ready_q   <= rx_ready_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_ready   = rx_ready_q;
  assign rx_busy    = (state_q != StIdle);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
8-N-1 UART receive path; the counterpart to the existing transmitter on the same serial link.
- Samples asynchronous RxD at 16x the baud rate and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB first and checks the stop bit.
- Presents the received byte through a ready/acknowledge handshake with overrun and framing-error reporting.
- Sits between the board RxD pin and user logic (LEDs, loopback into the transmitter).

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, serial bit rate
OVERSAMPLE, 16, ticks per bit; fixed at 16, mid-bit = tick 7

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
RxD  input  1  serial line, idle high, asynchronous to clk
rd_ack  input  1  consumer acknowledge; clears rx_ready and overrun
rx_data  output  8  last received byte, held until the next frame completes
rx_valid  output  1  one-cycle pulse when a good frame completes
rx_ready  output  1  level; unread byte present in rx_data
rx_busy  output  1  high from accepted start bit until stop sample
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
overrun  output  1  sticky; good frame completed while rx_ready=1
parity_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature)

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; rx_data=8'h00.
  - FSM to IDLE; synchroniser flops preset to 1.
- Synchroniser: RxD passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer, rounded to nearest.
  - Counter runs 0..DIV-1; tick is a one-clock pulse at DIV-1.
  - Counter restarts at 0 on the IDLE->START transition, so sampling phase aligns to the start edge.
- FSM, with a 4-bit tick count (tcnt) and a 3-bit bit index (bidx):
  - IDLE: wait for a falling edge (rxd_s 1 then 0). Go to START with tcnt=0. A line stuck low does not retrigger; it must go high first.
  - START: count ticks. At tcnt=7, if rxd_s=1 (false start) go to IDLE with no flags; otherwise go to DATA with tcnt=0 and bidx=0.
  - DATA: at tcnt=15, shift rxd_s into bit 7 of the shift register (LSB first). After bidx=7, go to STOP (or PARITY when enabled).
  - STOP: at tcnt=15 (mid stop bit), evaluate and return to IDLE on the same clock. Returning at mid-stop allows back-to-back frames.
- Stop evaluation:
  - rxd_s=1: rx_data <= shift register; rx_valid pulses 1 cycle; rx_ready <= 1.
  - rxd_s=0: frame_err pulses 1 cycle. rx_data, rx_valid and rx_ready are not updated.
- rx_busy = 1 in START (after the edge), DATA, PARITY and STOP; 0 in IDLE.
- Handshake:
  - rd_ack=1 clears rx_ready and overrun on the next clock.
  - A good frame completing while rx_ready=1 and rd_ack=0: overrun <= 1 (sticky), rx_data is overwritten with the new byte, rx_ready stays 1.
  - A good frame completing in the same cycle as rd_ack=1: rx_ready stays 1 and overrun is not set.
  - rd_ack while rx_ready=0: no effect.
- Latency: rx_valid asserts at most 9.5 bit periods + 4 clk after the RxD falling edge.
- Reset mid-frame: immediate abort. No pulse is generated after reset release until a fresh falling edge is seen.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8-E-1.
  - PARITY state follows DATA and samples the parity bit at tcnt=15.
  - Even parity is checked (XOR of the 8 data bits and the parity bit must be 0).
  - Mismatch: parity_err pulses 1 cycle together with the stop evaluation. The byte is discarded: no rx_valid, no rx_ready.
  - If the stop bit is also low, frame_err pulses as well.
- Undefined: no PARITY state; parity_err tied to 0. The port remains present.

Test Plan:
Bench parameters CLK_FREQ=1600000, BAUD=10000, giving DIV=10 and 160 clk per bit.
1. Send 8'hA5 with a good stop bit -> rx_valid one pulse; rx_data=8'hA5; rx_ready=1; frame_err=0; rx_valid within 1524 clk of the start edge.
2. Back-to-back 8'h3C then 8'hC3 with no idle gap, rd_ack pulsed after the first -> two rx_valid pulses; rx_data=8'hC3; overrun=0.
3. RxD low for 40 clk then high -> false start: back to IDLE; no rx_valid or frame_err; rx_busy drops 0 by clk 100 after the edge.
4. Send 8'h5A with the stop bit driven 0 -> frame_err one pulse; rx_valid=0; rx_data keeps its previous value; after the line returns high, a following 8'h01 frame is received correctly.
5. Send 8'h11 then 8'h22 with no rd_ack -> overrun=1, rx_data=8'h22; rd_ack pulse clears both rx_ready and overrun next clk.
6. reset=0 asserted mid-DATA during 8'hFF -> all outputs 0 immediately; no pulses after release; next 8'h81 frame received correctly. With UART_RX_PARITY_EN, sending 8'h07 with parity bit 0 -> parity_err pulse and no rx_valid.
